// File: rtl/operand_fetch.sv
// Operand fetch: owns the 32x32 register file, reads two sources with writeback bypass, scoreboards in-flight destinations.
// Latency: a request accepted at edge N presents its operand bundle (op_valid=1) from edge N+1.
// Backpressure: req_ready drops on RAW/WAW hazard, flush, or when the held bundle is not being consumed (op_valid & !op_ready).
//
// Ports:
//   clk, rst                     clock and synchronous active-high reset
//   wb_en/wb_reg/wb_data         writeback port: writes the register file and clears scoreboard bits
//   req_valid/req_ready          decoded-instruction handshake carrying req_rs1, req_rs2, req_rd, req_rd_write
//   op_valid/op_ready            operand bundle handshake carrying op_a, op_b, op_rd, op_rd_write
//   flush                        discard the held bundle and release its scoreboard bit
//   pending                      scoreboard bits, one per architectural register
module operand_fetch #(
  parameter int DATA_W = 32,
  parameter int NREGS  = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  // writeback
  input  logic              wb_en,
  input  logic [REG_AW-1:0] wb_reg,
  input  logic [DATA_W-1:0] wb_data,
  // decoded request
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [REG_AW-1:0] req_rs1,
  input  logic [REG_AW-1:0] req_rs2,
  input  logic [REG_AW-1:0] req_rd,
  input  logic              req_rd_write,
  // operand bundle to execute
  output logic              op_valid,
  input  logic              op_ready,
  output logic [DATA_W-1:0] op_a,
  output logic [DATA_W-1:0] op_b,
  output logic [REG_AW-1:0] op_rd,
  output logic              op_rd_write,
  // control / debug
  input  logic              flush,
  output logic [NREGS-1:0]  pending
);

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [REG_AW-1:0] rd;
    logic              rd_write;
  } op_bundle_t;

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  logic [DATA_W-1:0] regs_q [NREGS];
  logic [NREGS-1:0]  pending_q, pending_d;
  logic              op_valid_q, op_valid_d;
  op_bundle_t        op_q, op_d;

  // ---------------------------------------------------------------------
  // Decode of the writeback port against each requested index
  // ---------------------------------------------------------------------
  logic wb_live;
  logic wb_hits_rs1, wb_hits_rs2, wb_hits_rd;

  // A writeback to r0 is architecturally a no-op; it neither writes nor bypasses.
  assign wb_live     = wb_en && (wb_reg != '0);
  assign wb_hits_rs1 = wb_en && (wb_reg == req_rs1);
  assign wb_hits_rs2 = wb_en && (wb_reg == req_rs2);
  assign wb_hits_rd  = wb_en && (wb_reg == req_rd);

  // ---------------------------------------------------------------------
  // Source reads with same-cycle writeback bypass
  // ---------------------------------------------------------------------
  logic [DATA_W-1:0] rs1_val, rs2_val;

  always_comb begin
    rs1_val = regs_q[req_rs1];
    if (req_rs1 == '0) begin
      rs1_val = '0;
    end else if (wb_hits_rs1) begin
      rs1_val = wb_data;
    end
  end

  always_comb begin
    rs2_val = regs_q[req_rs2];
    if (req_rs2 == '0) begin
      rs2_val = '0;
    end else if (wb_hits_rs2) begin
      rs2_val = wb_data;
    end
  end

  // ---------------------------------------------------------------------
  // Hazard detection
  // ---------------------------------------------------------------------
  // A register whose result is arriving on writeback this cycle is no
  // longer a hazard: the bypass supplies the value for sources, and for
  // the destination the set-wins scoreboard rule keeps ordering intact.
  logic src1_busy, src2_busy, dst_busy;
  logic out_free;
  logic accept;

  assign src1_busy = pending_q[req_rs1] && (req_rs1 != '0) && !wb_hits_rs1;
  assign src2_busy = pending_q[req_rs2] && (req_rs2 != '0) && !wb_hits_rs2;
  assign dst_busy  = req_rd_write && (req_rd != '0) && pending_q[req_rd] && !wb_hits_rd;

  assign out_free  = !op_valid_q || op_ready;

  assign req_ready = !rst && !flush && out_free && !src1_busy && !src2_busy && !dst_busy;
  assign accept    = req_valid && req_ready;

  // ---------------------------------------------------------------------
  // Scoreboard next state
  // ---------------------------------------------------------------------
  // Order matters: clears first, then the set, so a same-cycle set on the
  // register being retired leaves the bit at 1.
  always_comb begin
    pending_d = pending_q;
    // A flushed bundle will never write back, so release its destination.
    if (flush && op_valid_q && op_q.rd_write && (op_q.rd != '0)) begin
      pending_d[op_q.rd] = 1'b0;
    end
    if (wb_en) begin
      pending_d[wb_reg] = 1'b0;
    end
    if (accept && req_rd_write && (req_rd != '0)) begin
      pending_d[req_rd] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  // ---------------------------------------------------------------------
  // Output stage next state
  // ---------------------------------------------------------------------
  always_comb begin
    op_valid_d = op_valid_q;
    op_d       = op_q;
    if (flush) begin
      op_valid_d = 1'b0;
    end else if (accept) begin
      op_valid_d  = 1'b1;
      op_d.a        = rs1_val;
      op_d.b        = rs2_val;
      op_d.rd       = req_rd;
      op_d.rd_write = req_rd_write;
    end else if (op_ready) begin
      op_valid_d = 1'b0;
    end
  end

  // ---------------------------------------------------------------------
  // Sequential state
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wb_live) begin
      regs_q[wb_reg] <= wb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q  <= '0;
      op_valid_q <= 1'b0;
      op_q       <= '0;
    end else begin
      pending_q  <= pending_d;
      op_valid_q <= op_valid_d;
      op_q       <= op_d;
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign op_valid    = op_valid_q;
  assign op_a        = op_q.a;
  assign op_b        = op_q.b;
  assign op_rd       = op_q.rd;
  assign op_rd_write = op_q.rd_write;
  assign pending     = pending_q;

endmodule

// File: doc/operand_fetch.md
Name: operand_fetch

Overview:
- Read side of the CPU register file.
- Owns the 32x32 architectural register file, which is written by the writeback port.
- Accepts decoded instructions over a valid/ready handshake and reads two source operands, with same-cycle writeback bypass.
- Tracks in-flight destination registers in a scoreboard and stalls on RAW/WAW hazards.
- Presents operands to execute through a one-entry registered output stage.

Parameters:
- DATA_W, 32, register width in bits.
- NREGS, 32, number of architectural registers; register 0 is hardwired zero.
- REG_AW, 5, register index width (log2 NREGS).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- wb_en  input  1  writeback write enable.
- wb_reg  input  REG_AW  writeback destination index.
- wb_data  input  DATA_W  writeback data.
- req_valid  input  1  decoded instruction is present.
- req_ready  output  1  block accepts the request this cycle.
- req_rs1  input  REG_AW  source register 1.
- req_rs2  input  REG_AW  source register 2.
- req_rd  input  REG_AW  destination register.
- req_rd_write  input  1  instruction will write req_rd.
- op_valid  output  1  operand bundle valid.
- op_ready  input  1  execute consumes the bundle.
- op_a  output  DATA_W  value of rs1.
- op_b  output  DATA_W  value of rs2.
- op_rd  output  REG_AW  destination, passed through.
- op_rd_write  output  1  write flag, passed through.
- flush  input  1  discard the held bundle.
- pending  output  NREGS  scoreboard bits, for debug and verification.

Behaviour:
- Reset (rst=1 at an edge):
  - all registers <= 0; pending <= 0.
  - op_valid <= 0; op_a, op_b, op_rd, op_rd_write <= 0.
  - rst has priority over every other input, including mid-handshake.
- Register write: if wb_en and wb_reg != 0, reg[wb_reg] <= wb_data at the edge. Writes to reg 0 are ignored.
- Pending set: pending[rd] is set at the edge where a request with req_rd_write=1 and req_rd != 0 is accepted.
- Pending clear: wb_en with wb_reg = r clears pending[r] at the edge.
- Scoreboard collision: if a set and a clear hit the same register in the same cycle, the set wins and the bit stays 1.
- Read value (combinational): rsX==0 yields 0. Otherwise, if wb_en and wb_reg==rsX, yield wb_data (bypass). Otherwise yield reg[rsX].
- Source hazard: srcX_busy = pending[rsX] and rsX != 0, and not (wb_en and wb_reg==rsX).
- Destination hazard: dst_busy = req_rd_write and req_rd != 0 and pending[req_rd], and not (wb_en and wb_reg==req_rd). This covers WAW.
- Handshake: req_ready = !rst and !flush and (!op_valid or op_ready) and !src1_busy and !src2_busy and !dst_busy.
  - req_ready may depend on req_* fields.
  - A request is accepted when req_valid and req_ready.
- Latency: accepted at edge N gives op_valid=1 at N+1, with op_a/op_b captured at edge N using the bypassed read values.
- Output stage:
  - Holds its contents stable while op_valid and !op_ready.
  - Accept while op_ready=1 replaces the bundle (back-to-back throughput of 1 per cycle).
  - op_ready with no accept gives op_valid <= 0.
- Flush:
  - At the edge, op_valid <= 0.
  - If the held bundle had op_valid and op_rd_write and op_rd != 0, clear pending[op_rd], unless a same-cycle wb already clears it; the result is the same.
  - No request is accepted during flush.
  - Pending bits for instructions already passed downstream are untouched.
- Hold stability: a stalled request (req_valid=1, req_ready=0) has no side effects.

Test Plan:
- Reset then read: rst 1 cycle, req rs1=3, rs2=0 -> next cycle op_valid=1, op_a=0, op_b=0, pending=0.
- Write then read: wb r5=0xDEADBEEF at edge N; req rs1=5 accepted at N+1 -> op_a=0xDEADBEEF. Also wb r0=0x1234 followed by a read of r0 -> op_a=0.
- Same-cycle bypass: wb r7=0xA5A5A5A5 in the same cycle as accepted req rs2=7 -> op_b=0xA5A5A5A5 at the next edge, with no stall.
- RAW stall: accept rd=9 write; next req rs1=9 -> req_ready=0 until wb r9=0x55 arrives. In the wb cycle req_ready=1 and op_a=0x55; pending[9] ends 0.
- WAW / set-wins collision:
  - Accept req rd=4 write. Next request writes rd=4 -> stalled.
  - When wb r4 arrives it is accepted in the same cycle.
  - pending[4] remains 1 afterwards.
- Backpressure and flush:
  - op_ready=0 for 3 cycles -> op_a/op_b/op_rd stable and req_ready=0.
  - Assert flush while holding rd=12 write -> op_valid=0 and pending[12]=0 on the next cycle.
